regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/regfile_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, legal register ID range and FSM encoding for the write arbiter
package regfile_pkg;

    localparam int ID_W       = 6;
    localparam int DATA_W     = 32;
    localparam int REG_ID_MIN = 1;
    localparam int REG_ID_MAX = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, priority starting at ptr and wrapping modulo N_REQ
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   grant_rot;
    logic [2*N_REQ-1:0] grant_dbl;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        req_rot   = req_dbl[N_REQ-1:0];
        grant_rot = req_rot & (~req_rot + {{(N_REQ-1){1'b0}}, 1'b1});
        grant_dbl = {grant_rot, grant_rot} << ptr;
        grant     = grant_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin register-file write arbiter; WARB_CLEAR_EN adds the clear-all sequence
module regfile_wr_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ID_W   = regfile_pkg::ID_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ID_W-1:0]   req_id,
    input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef WARB_CLEAR_EN
    input  logic                    clear_start,
`endif
    output logic                    write,
    output logic [ID_W-1:0]         WriteRegID,
    output logic [DATA_W-1:0]       WriteData,
    output logic                    busy,
    output logic                    err_drop
);
    import regfile_pkg::*;

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [N_REQ-1:0]   grant;
    logic               clear_go;
    logic               hs;
    logic               legal;
    logic [ID_W-1:0]    win_id;
    logic [DATA_W-1:0]  win_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

`ifdef WARB_CLEAR_EN
    // clr_cnt tracks the ID currently being presented on the write port while in CLEAR.
    logic [ID_W-1:0] clr_cnt;

    assign clear_go = (state == ST_IDLE) && clear_start;
    assign busy     = (state == ST_CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == ID_W'(REG_ID_MAX)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end
`else
    assign clear_go  = 1'b0;
    assign busy      = 1'b0;
    assign state_nxt = ST_IDLE;
`endif

    assign req_ready = (!reset && state == ST_IDLE && !clear_go) ? grant : '0;
    assign hs        = |req_ready;

    always_comb begin
        win_id   = '0;
        win_data = '0;
        ptr_nxt  = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                win_id   = req_id[i*ID_W +: ID_W];
                win_data = req_data[i*DATA_W +: DATA_W];
                ptr_nxt  = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    assign legal = (win_id >= ID_W'(REG_ID_MIN)) && (win_id <= ID_W'(REG_ID_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            write      <= 1'b0;
            WriteRegID <= '0;
            WriteData  <= '0;
            err_drop   <= 1'b0;
`ifdef WARB_CLEAR_EN
            clr_cnt    <= ID_W'(REG_ID_MIN);
`endif
        end else begin
            write    <= 1'b0;
            err_drop <= 1'b0;
            if (hs) begin
                rr_ptr <= ptr_nxt;
                if (legal) begin
                    write      <= 1'b1;
                    WriteRegID <= win_id;
                    WriteData  <= win_data;
                end else begin
                    err_drop <= 1'b1;
                end
            end
`ifdef WARB_CLEAR_EN
            if (clear_go) begin
                write      <= 1'b1;
                WriteRegID <= ID_W'(REG_ID_MIN);
                WriteData  <= '0;
                clr_cnt    <= ID_W'(REG_ID_MIN);
            end else if (state == ST_CLEAR) begin
                if (clr_cnt != ID_W'(REG_ID_MAX)) begin
                    write      <= 1'b1;
                    WriteRegID <= clr_cnt + 1'b1;
                    WriteData  <= '0;
                    clr_cnt    <= clr_cnt + 1'b1;
                end else begin
                    clr_cnt <= ID_W'(REG_ID_MIN);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [17:0] req_id;
    logic [95:0] req_data;
`ifdef WARB_CLEAR_EN
    logic        clear_start;
`endif
    logic        write;
    logic [5:0]  WriteRegID;
    logic [31:0] WriteData;
    logic        busy;
    logic        err_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_id      (req_id),
        .req_data    (req_data),
`ifdef WARB_CLEAR_EN
        .clear_start (clear_start),
`endif
        .write       (write),
        .WriteRegID  (WriteRegID),
        .WriteData   (WriteData),
        .busy        (busy),
        .err_drop    (err_drop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] id, input logic [31:0] d);
        req_id[i*6 +: 6]    = id;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
`ifdef WARB_CLEAR_EN
        clear_start = 1'b0;
`endif
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 3'b111;
        req_id    = '0;
        req_data  = '0;
`ifdef WARB_CLEAR_EN
        clear_start = 1'b0;
`endif
        set_req(0, 6'd1, 32'h11);
        tick();
        tick();
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_write", write, 1'b0);
        chk("rst_id", WriteRegID, 6'd0);
        chk("rst_data", WriteData, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_drop, 1'b0);

        // single requester 1
        reset     = 1'b0;
        req_valid = 3'b000;
        set_req(1, 6'd5, 32'h0000_00AA);
        req_valid = 3'b010;
        #1;
        chk("one_ready", req_ready, 3'b010);
        tick();
        chk("one_write", write, 1'b1);
        chk("one_id", WriteRegID, 6'd5);
        chk("one_data", WriteData, 32'hAA);
        chk("one_err", err_drop, 1'b0);
        req_valid = 3'b000;
        tick();
        chk("idle_write", write, 1'b0);
        chk("idle_hold_id", WriteRegID, 6'd5);
        chk("idle_hold_data", WriteData, 32'hAA);

        // three persistent requesters rotate 0,1,2,0,1,2 from reset
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 6'(i + 1), 32'h101 + 32'(i));
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", req_ready, 64'(3'b001 << (k % 3)));
            tick();
            chk("rr_write", write, 1'b1);
            chk("rr_id", WriteRegID, 64'((k % 3) + 1));
            chk("rr_data", WriteData, 64'(32'h101 + (k % 3)));
        end
        req_valid = 3'b000;
        tick();
        chk("rr_idle_write", write, 1'b0);
        chk("rr_busy", busy, 1'b0);

        // illegal IDs are accepted and dropped; 32 is legal, 33 is not
        do_reset();
        set_req(2, 6'd0, 32'hBEEF);
        req_valid = 3'b100;
        #1;
        chk("drop0_ready", req_ready, 3'b100);
        tick();
        chk("drop0_write", write, 1'b0);
        chk("drop0_err", err_drop, 1'b1);
        set_req(2, 6'd40, 32'hBEEF);
        #1;
        chk("drop40_ready", req_ready, 3'b100);
        tick();
        chk("drop40_write", write, 1'b0);
        chk("drop40_err", err_drop, 1'b1);
        set_req(2, 6'd32, 32'h32);
        tick();
        chk("id32_write", write, 1'b1);
        chk("id32_id", WriteRegID, 6'd32);
        chk("id32_err", err_drop, 1'b0);
        set_req(2, 6'd33, 32'h33);
        tick();
        chk("drop33_write", write, 1'b0);
        chk("drop33_err", err_drop, 1'b1);
        chk("drop33_hold_id", WriteRegID, 6'd32);
        req_valid = 3'b000;
        tick();
        chk("drop_err_end", err_drop, 1'b0);
        chk("drop_busy", busy, 1'b0);

`ifdef WARB_CLEAR_EN
        // clear wins over requests; rr_ptr survives the sequence
        do_reset();
        set_req(0, 6'd7, 32'h7);
        req_valid = 3'b001;
        tick();
        for (int i = 0; i < 3; i++) set_req(i, 6'(i + 1), 32'h101 + 32'(i));
        req_valid   = 3'b111;
        clear_start = 1'b1;
        #1;
        chk("clr_start_ready", req_ready, 3'b000);
        tick();
        clear_start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            chk("clr_write", write, 1'b1);
            chk("clr_id", WriteRegID, 64'(k));
            chk("clr_data", WriteData, 32'd0);
            chk("clr_busy", busy, 1'b1);
            chk("clr_ready", req_ready, 3'b000);
            clear_start = (k == 5);
            tick();
            clear_start = 1'b0;
        end
        chk("clr_end_write", write, 1'b0);
        chk("clr_end_busy", busy, 1'b0);
        chk("clr_end_ready", req_ready, 3'b010);
        tick();
        chk("clr_after_write", write, 1'b1);
        chk("clr_after_id", WriteRegID, 6'd2);
        chk("clr_after_data", WriteData, 32'h102);
        req_valid = 3'b000;
        tick();

        // reset in the middle of a clear sequence
        do_reset();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("abort_pre_id", WriteRegID, 6'd10);
        reset = 1'b1;
        #1;
        chk("abort_write", write, 1'b0);
        chk("abort_id", WriteRegID, 6'd0);
        chk("abort_data", WriteData, 32'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err_drop, 1'b0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_post_write", write, 1'b0);
            chk("abort_post_busy", busy, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
